// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// One outstanding transaction; data has priority, with a streak limit that forces fetch through.
module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [3:0]    d_be,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [3:0]    mem_be,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          err_spurious
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t        state_q, state_d;
    logic          own_d_q, own_d_d;
    logic [3:0]    streak_q, streak_d;
    logic          err_q, err_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;

    logic issue;
    logic sel_d;
    logic resp;

    always_comb begin
        state_d    = state_q;
        own_d_d    = own_d_q;
        streak_d   = streak_q;
        err_d      = err_q | (mem_rvalid && (state_q != S_WAIT));
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        issue      = 1'b0;
        sel_d      = own_d_q;
        resp       = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_be     = 4'h0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        if_rvalid  = 1'b0;
        d_rvalid   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (d_req && (!if_req || (streak_q < LIMIT))) begin
                    sel_d = 1'b1;
                    issue = 1'b1;
                end else if (if_req) begin
                    sel_d = 1'b0;
                    issue = 1'b1;
                end
                if (issue) begin
                    own_d_d = sel_d;
                    state_d = mem_gnt ? S_WAIT : S_REQ;
                end
            end
            S_REQ: begin
                issue = 1'b1;
                if (mem_gnt) state_d = S_WAIT;
            end
            S_WAIT: begin
                resp = mem_rvalid;
                if (mem_rvalid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are forced quiet while reset is held so an aborted transfer never leaks.
        issue = issue & rst_n;
        resp  = resp & rst_n;

        if (issue) begin
            mem_req = 1'b1;
            if (sel_d) begin
                mem_we    = d_we;
                mem_be    = d_be;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
            end else begin
                mem_be   = 4'hF;
                mem_addr = if_addr;
            end
            if (mem_gnt) begin
                if (sel_d) begin
                    d_gnt = 1'b1;
                    if (!if_req)               streak_d = 4'd0;
                    else if (streak_q != 4'hF) streak_d = streak_q + 4'd1;
                end else begin
                    if_gnt   = 1'b1;
                    streak_d = 4'd0;
                end
            end
        end

        if (resp) begin
            if (own_d_q) begin
                d_rvalid  = 1'b1;
                d_rdata_d = mem_rdata;
            end else begin
                if_rvalid  = 1'b1;
                if_rdata_d = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            own_d_q    <= 1'b0;
            streak_q   <= 4'd0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            own_d_q    <= own_d_d;
            streak_q   <= streak_d;
            err_q      <= err_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign if_rdata     = if_rvalid ? mem_rdata : if_rdata_q;
    assign d_rdata      = d_rvalid ? mem_rdata : d_rdata_q;
    assign busy         = (state_q != S_IDLE);
    assign err_spurious = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Cycle-level bench for mem_port_arbiter: vector table, starvation and reset sequences.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, d_req, d_we, mem_gnt, mem_rvalid;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_be;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, busy, err_spurious;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_if_rdata, exp_d_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy), .err_spurious(err_spurious)
    );

    // An unaccepted request must still be backed by a requester next cycle.
    ap_req_held: assert property (@(posedge clk) disable iff (!rst_n)
        (mem_req && !mem_gnt) |=> (if_req || d_req));

    typedef struct {
        logic ir; logic [31:0] ia;
        logic dr; logic dw; logic [3:0] dbe; logic [31:0] da; logic [31:0] dwd;
        logic mg; logic mr; logic [31:0] mrd;
        logic emr; logic ewe; logic [3:0] ebe; logic [31:0] ea; logic [31:0] ewd;
        logic eig; logic edg; logic eiv; logic edv; logic eb; logic ee;
    } vec_t;

    vec_t sb_q[$];

    function automatic vec_t mk(
        input logic ir, input logic [31:0] ia,
        input logic dr, input logic dw, input logic [3:0] dbe, input logic [31:0] da, input logic [31:0] dwd,
        input logic mg, input logic mr, input logic [31:0] mrd,
        input logic emr, input logic ewe, input logic [3:0] ebe, input logic [31:0] ea, input logic [31:0] ewd,
        input logic eig, input logic edg, input logic eiv, input logic edv, input logic eb, input logic ee);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.dbe = dbe; v.da = da; v.dwd = dwd;
        v.mg = mg; v.mr = mr; v.mrd = mrd;
        v.emr = emr; v.ewe = ewe; v.ebe = ebe; v.ea = ea; v.ewd = ewd;
        v.eig = eig; v.edg = edg; v.eiv = eiv; v.edv = edv; v.eb = eb; v.ee = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        if_req = v.ir; if_addr = v.ia;
        d_req = v.dr; d_we = v.dw; d_be = v.dbe; d_addr = v.da; d_wdata = v.dwd;
        mem_gnt = v.mg; mem_rvalid = v.mr; mem_rdata = v.mrd;
    endtask

    // Entered just after a rising edge; leaves just after the next one.
    task automatic step(input vec_t v);
        vec_t e;
        drive(v);
        sb_q.push_back(v);
        @(negedge clk);
        e = sb_q.pop_front();
        if (e.eiv) exp_if_rdata = e.mrd;
        if (e.edv) exp_d_rdata = e.mrd;
        chk("mem_req", 32'(mem_req), 32'(e.emr));
        chk("if_gnt", 32'(if_gnt), 32'(e.eig));
        chk("d_gnt", 32'(d_gnt), 32'(e.edg));
        chk("if_rvalid", 32'(if_rvalid), 32'(e.eiv));
        chk("d_rvalid", 32'(d_rvalid), 32'(e.edv));
        chk("busy", 32'(busy), 32'(e.eb));
        chk("err_spurious", 32'(err_spurious), 32'(e.ee));
        chk("if_rdata", if_rdata, exp_if_rdata);
        chk("d_rdata", d_rdata, exp_d_rdata);
        if (e.emr) begin
            chk("mem_addr", mem_addr, e.ea);
            chk("mem_we", 32'(mem_we), 32'(e.ewe));
            chk("mem_be", 32'(mem_be), 32'(e.ebe));
            if (e.ewe) chk("mem_wdata", mem_wdata, e.ewd);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0));
        exp_if_rdata = '0;
        exp_d_rdata  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    vec_t tbl[$];

    initial begin
        logic dwin;
        logic [31:0] da;

        // single fetch
        tbl.push_back(mk(1,'h18,0,0,0,0,0,1,0,0,        1,0,'hF,'h18,0,        1,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,            0,0,0,0,0,             0,0,0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,'h13,         0,0,0,0,0,             0,0,1,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,            0,0,0,0,0,             0,0,0,0,0,0));
        // contention: data first, then the held fetch
        tbl.push_back(mk(1,'h20,1,0,'hF,'h100,0,1,0,0,   1,0,'hF,'h100,0,       0,1,0,0,0,0));
        tbl.push_back(mk(1,'h20,0,0,0,0,0,0,1,'hCAFE,    0,0,0,0,0,             0,0,0,1,1,0));
        tbl.push_back(mk(1,'h20,0,0,0,0,0,1,0,0,         1,0,'hF,'h20,0,        1,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,'h1111,       0,0,0,0,0,             0,0,1,0,1,0));
        // backpressure: fetch stays owner while d_req rises
        tbl.push_back(mk(1,'h40,0,0,0,0,0,0,0,0,         1,0,'hF,'h40,0,        0,0,0,0,0,0));
        tbl.push_back(mk(1,'h40,1,0,'hF,'h200,0,0,0,0,   1,0,'hF,'h40,0,        0,0,0,0,1,0));
        tbl.push_back(mk(1,'h40,1,0,'hF,'h200,0,0,0,0,   1,0,'hF,'h40,0,        0,0,0,0,1,0));
        tbl.push_back(mk(1,'h40,1,0,'hF,'h200,0,1,0,0,   1,0,'hF,'h40,0,        1,0,0,0,1,0));
        tbl.push_back(mk(0,0,1,0,'hF,'h200,0,0,1,'h2222, 0,0,0,0,0,             0,0,1,0,1,0));
        tbl.push_back(mk(0,0,1,0,'hF,'h200,0,1,0,0,      1,0,'hF,'h200,0,       0,1,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,'h3333,       0,0,0,0,0,             0,0,0,1,1,0));
        // store with ack
        tbl.push_back(mk(0,0,1,1,'h3,'h300,'hABCD1234,1,0,0, 1,1,'h3,'h300,'hABCD1234, 0,1,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0,            0,0,0,0,0,             0,0,0,1,1,0));
        // spurious response in IDLE, then gnt and rvalid together
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,'hDEAD,       0,0,0,0,0,             0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,            0,0,0,0,0,             0,0,0,0,0,1));
        tbl.push_back(mk(1,'h50,0,0,0,0,0,1,1,'h5555,    1,0,'hF,'h50,0,        1,0,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,'h6666,       0,0,0,0,0,             0,0,1,0,1,1));

        do_reset();
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset mem_req", 32'(mem_req), 32'd0);
        chk("reset err", 32'(err_spurious), 32'd0);

        foreach (tbl[i]) step(tbl[i]);

        // abort mid-WAIT with the fetch request still asserted
        step(mk(1,'h60,0,0,0,0,0,1,0,0, 1,0,'hF,'h60,0, 1,0,0,0,0,1));
        drive(mk(1,'h60,0,0,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0));
        #2;
        chk("pre-reset busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async busy", 32'(busy), 32'd0);
        chk("async mem_req", 32'(mem_req), 32'd0);
        chk("async if_gnt", 32'(if_gnt), 32'd0);
        chk("async err", 32'(err_spurious), 32'd0);
        chk("async if_rdata", if_rdata, 32'd0);
        chk("async d_rdata", d_rdata, 32'd0);
        chk("async mem_addr", mem_addr, 32'd0);
        exp_if_rdata = '0;
        exp_d_rdata  = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(mk(0,0,0,0,0,0,0,0,1,'h7777, 0,0,0,0,0, 0,0,0,0,0,0));
        step(mk(0,0,0,0,0,0,0,0,0,0,      0,0,0,0,0, 0,0,0,0,0,1));

        // starvation guard: four data grants, one fetch, then data again
        do_reset();
        for (int i = 0; i < 6; i++) begin
            dwin = (i != 4);
            da   = 32'h400 + 32'(i) * 4;
            step(mk(1,'h80,1,0,'hF,da,0,1,0,0,
                    1,0,'hF,(dwin ? da : 32'h80),0, !dwin,dwin,0,0,0,0));
            step(mk(1,'h80,1,0,'hF,da,0,0,1,32'h1000 + 32'(i),
                    0,0,0,0,0, 0,0,!dwin,dwin,1,0));
        end

        chk("scoreboard empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port of the rv32i core between instruction fetch (IF) and load/store (D).
- Sits between the core and the unified instruction/data memory.
- Sequences one outstanding transaction at a time through a request/grant/response handshake.
- Arbitration is data-priority with a starvation guard for fetch.

Parameters:
- AW, 32, address width
- DW, 32, data width
- STARVE_LIMIT, 4, consecutive D grants allowed while IF is pending before IF is forced to win (range 1..15)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  AW  fetch address
- if_gnt  out  1  fetch request accepted by memory
- if_rvalid  out  1  fetch data valid, one cycle
- if_rdata  out  DW  fetch data
- d_req  in  1  data request; held with d_* until d_gnt
- d_we  in  1  1 = store
- d_be  in  4  byte enables
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_gnt  out  1  data request accepted
- d_rvalid  out  1  load data or store ack, one cycle
- d_rdata  out  DW  load data
- mem_req  out  1  request to memory
- mem_we  out  1  write
- mem_be  out  4  byte enables
- mem_addr  out  AW  address
- mem_wdata  out  DW  write data
- mem_gnt  in  1  memory accepts the request this cycle
- mem_rvalid  in  1  response valid
- mem_rdata  in  DW  response data
- busy  out  1  state != IDLE
- err_spurious  out  1  sticky: mem_rvalid seen outside WAIT

Behaviour:
- Reset (async, rst_n=0):
  - State returns to IDLE; owner=IF; streak=0; err_spurious=0.
  - All gnt/rvalid/mem_req outputs are 0.
  - rdata, addr, wdata and be outputs are 0.
- States:
  - IDLE: no transaction.
  - REQ: winner latched, mem_req held until mem_gnt.
  - WAIT: accepted, awaiting mem_rvalid.
- IDLE:
  - Winner is chosen combinationally:
    - If d_req and (!if_req or streak < STARVE_LIMIT), D wins.
    - Otherwise, if if_req, IF wins.
  - mem_req=1 and mem_* are driven from the winner in the same cycle (zero-cycle request latency).
  - IF drives mem_we=0 and mem_be=4'hF.
  - If mem_gnt is high, the winner's gnt is 1 in the same cycle and the next state is WAIT. Otherwise the owner is latched and the next state is REQ.
- REQ:
  - mem_req=1 with the latched owner's signals; no re-arbitration.
  - On mem_gnt: owner gnt=1, go to WAIT.
  - The owner dropping req in REQ is illegal; the bench asserts on it.
- WAIT:
  - mem_req=0.
  - On mem_rvalid: owner rvalid=1 and owner rdata=mem_rdata in the same cycle, then go to IDLE.
  - Stores also receive rvalid as an ack.
  - The non-owner rvalid stays 0.
  - A new request is issued at the earliest the cycle after rvalid, so throughput is 1 transaction per (grant latency + response latency + 1) cycles.
- if_rdata/d_rdata hold their last value between responses.
- Starvation counter (4-bit), updated on each grant:
  - D granted while if_req=1: streak+1.
  - D granted while if_req=0: streak=0.
  - IF granted: streak=0.
- Simultaneous mem_gnt and mem_rvalid in IDLE/REQ: the gnt is processed, and the rvalid is spurious.
- mem_rvalid outside WAIT is dropped: no rvalid is forwarded and err_spurious=1 (sticky until reset).
- Reset asserted in REQ/WAIT aborts the transaction. A late memory response after reset deasserts is spurious by definition and sets err_spurious.
- With no requests, the arbiter stays in IDLE with mem_req=0.

Test Plan:
- Single fetch: if_req, if_addr=0x18, mem_gnt=1 immediately, mem_rvalid 2 cycles later with 0x00000013 -> mem_req/if_gnt in cycle 0; if_rvalid=1 and if_rdata=0x13 exactly one cycle; busy back to 0 the next cycle.
- Contention: if_req and d_req (load, 0x100) both high, mem_gnt=1 -> d_gnt first; IF is served after d_rvalid; mem_addr sequence is 0x100 then fetch address.
- Starvation: if_req held high, d_req high continuously, STARVE_LIMIT=4 -> exactly 4 D grants, then IF granted, streak back to 0, then D again.
- Memory backpressure: mem_gnt low for 3 cycles with IF winning, and d_req rising in cycle 1 -> mem_addr stays if_addr (no switch to D); if_gnt on the first mem_gnt cycle.
- Store ack: d_we=1, d_be=4'b0011, d_wdata=0xABCD1234 -> mem_we=1, mem_be=3, mem_wdata matches; d_rvalid=1 on mem_rvalid; if_rvalid=0.
- Spurious response and reset: mem_rvalid pulse in IDLE -> err_spurious=1 and stays 1, no rvalid forwarded. rst_n low mid-WAIT -> outputs 0 immediately (asynchronously) and err_spurious cleared.
